multadd_seq: RTL and testbench

Sequential multiply-add responder computing y = x1*x2 + x3 on 10-bit unsigned operands. It is the hardware-side counterpart of the vector-driven multiply-add bench flow: it accepts operand triples through a valid/ready handshake and returns results through a second valid/ready handshake. It uses an iterative shift-add multiplier in place of a combinational array, and is the datapath the lab sequencer and checker logic drive.

---
 rtl/multadd_seq_if.sv | 24 ++
 rtl/multadd_seq.sv | 117 +++++++++++
 tb/tb_multadd_seq.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/multadd_seq_if.sv
// Operand/result handshake bundle for multadd_seq: valid/ready in, valid/ready out.
interface multadd_seq_if #(
  parameter int W = 10
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x1;
  logic [W-1:0] x2;
  logic [W-1:0] x3;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
  logic         ovf;

  modport master (
    output in_valid, x1, x2, x3, out_ready,
    input  in_ready, out_valid, y, ovf
  );

  modport slave (
    input  in_valid, x1, x2, x3, out_ready,
    output in_ready, out_valid, y, ovf
  );
endinterface

// File: rtl/multadd_seq.sv
// Sequential y = x1*x2 + x3 with a one-bit-per-cycle shift-add multiplier.
// Define MULTADD_SAT_EN to clamp y to all-ones whenever ovf is raised.
module multadd_seq #(
  parameter int W    = 10,
  parameter int FRAC = 0
) (
  input logic          clk,
  input logic          reset,
  multadd_seq_if.slave bus
);
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, MUL, ADD, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   x1_q, x1_d;
  logic [W-1:0]   x2_q, x2_d;
  logic [W-1:0]   x3_q, x3_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [CW-1:0]  count_q, count_d;
  logic [W-1:0]   y_q, y_d;
  logic           ovf_q, ovf_d;
  logic           outValid_q, outValid_d;

  logic [2*W-1:0] partial;
  logic [W:0]     prodSlice;
  logic [W:0]     sum;
  logic           ovfRaw;

  // Scaled product plus addend; overflow covers dropped high product bits and the add carry.
  always_comb begin
    partial   = {{W{1'b0}}, x1_q} << count_q;
    prodSlice = {1'b0, acc_q[W-1+FRAC:FRAC]};
    sum       = prodSlice + {1'b0, x3_q};
    ovfRaw    = (acc_q[2*W-1:W+FRAC] != '0) | sum[W];
  end

  always_comb begin
    state_d    = state_q;
    x1_d       = x1_q;
    x2_d       = x2_q;
    x3_d       = x3_q;
    acc_d      = acc_q;
    count_d    = count_q;
    y_d        = y_q;
    ovf_d      = ovf_q;
    outValid_d = outValid_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          x1_d    = bus.x1;
          x2_d    = bus.x2;
          x3_d    = bus.x3;
          acc_d   = '0;
          count_d = '0;
          state_d = MUL;
        end
      end
      MUL: begin
        if (x2_q[count_q]) begin
          acc_d = acc_q + partial;
        end
        count_d = count_q + CW'(1);
        if (count_q == CW'(W - 1)) begin
          state_d = ADD;
        end
      end
      ADD: begin
`ifdef MULTADD_SAT_EN
        y_d = ovfRaw ? {W{1'b1}} : sum[W-1:0];
`else
        y_d = sum[W-1:0];
`endif
        ovf_d      = ovfRaw;
        outValid_d = 1'b1;
        state_d    = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          outValid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      x1_q       <= '0;
      x2_q       <= '0;
      x3_q       <= '0;
      acc_q      <= '0;
      count_q    <= '0;
      y_q        <= '0;
      ovf_q      <= 1'b0;
      outValid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      x1_q       <= x1_d;
      x2_q       <= x2_d;
      x3_q       <= x3_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      y_q        <= y_d;
      ovf_q      <= ovf_d;
      outValid_q <= outValid_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = outValid_q;
  assign bus.y         = y_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_multadd_seq.sv
// Directed bench for multadd_seq: FRAC=0 instance for the main flow, FRAC=4 instance for scaling.
module tb_multadd_seq;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   checkCount = 0;
  int   errorCount = 0;
  int   acceptCyc  = 0;
  int   validCyc   = 0;

  multadd_seq_if #(.W(10)) bus ();
  multadd_seq_if #(.W(10)) bus4 ();

  multadd_seq #(.W(10), .FRAC(0)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  multadd_seq #(.W(10), .FRAC(4)) dut4 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference y/ovf straight from a full-width product, independent of the iterative datapath.
  function automatic logic [10:0] model(input logic [9:0] a, input logic [9:0] b,
                                         input logic [9:0] c, input int frac);
    logic [19:0] prod;
    logic [19:0] scaled;
    logic [10:0] s;
    logic        o;
    logic [9:0]  r;
    prod   = {10'd0, a} * {10'd0, b};
    scaled = prod >> frac;
    s      = {1'b0, scaled[9:0]} + {1'b0, c};
    o      = ((prod >> (10 + frac)) != 20'd0) | s[10];
    r      = s[9:0];
`ifdef MULTADD_SAT_EN
    if (o) r = 10'h3FF;
`endif
    return {o, r};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
    int n = 0;
    while (!bus.in_ready && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("inReadyBeforeAccept", 32'(bus.in_ready), 32'd1);
    bus.x1       = a;
    bus.x2       = b;
    bus.x3       = c;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    acceptCyc    = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic waitValid();
    int n = 0;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    validCyc = cyc;
    checkOutput("outValidSeen", 32'(bus.out_valid), 32'd1);
  endtask

  // Accept, wait, check result and latency, then let the always-ready consumer take it.
  task automatic runVector(input string tag, input logic [9:0] a, input logic [9:0] b,
                           input logic [9:0] c, input logic [9:0] expY, input logic expOvf);
    applyStimulus(a, b, c);
    waitValid();
    checkOutput({tag, ".latency"}, 32'(validCyc - acceptCyc + 1), 32'd12);
    checkOutput({tag, ".y"}, 32'(bus.y), 32'(expY));
    checkOutput({tag, ".ovf"}, 32'(bus.ovf), 32'(expOvf));
    @(posedge clk);
    #1;
    checkOutput({tag, ".inReadyAfter"}, 32'(bus.in_ready), 32'd1);
    checkOutput({tag, ".outValidAfter"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    logic [10:0] exp;
    logic [9:0]  a, b, c;
    int          prevAccept;
    int          n;

    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b1;
    bus.x1         = '0;
    bus.x2         = '0;
    bus.x3         = '0;
    bus4.in_valid  = 1'b0;
    bus4.out_ready = 1'b1;
    bus4.x1        = '0;
    bus4.x2        = '0;
    bus4.x3        = '0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.inReady", 32'(bus.in_ready), 32'd1);
    checkOutput("reset.outValid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset.y", 32'(bus.y), 32'd0);
    checkOutput("reset.ovf", 32'(bus.ovf), 32'd0);
    #2 reset = 1'b0;

    runVector("basic", 10'h003, 10'h005, 10'h007, 10'h016, 1'b0);

`ifdef MULTADD_SAT_EN
    runVector("overflow", 10'h3FF, 10'h3FF, 10'h002, 10'h3FF, 1'b1);
`else
    runVector("overflow", 10'h3FF, 10'h3FF, 10'h002, 10'h003, 1'b1);
`endif
    runVector("carryOnly", 10'h001, 10'h3FF, 10'h001, model(10'h001, 10'h3FF, 10'h001, 0), 1'b1);

    // FRAC=4 instance: 0x40*0x30 = 0xC00, >>4 = 0xC0, +5 = 0xC5.
    bus4.x1 = 10'h040;
    bus4.x2 = 10'h030;
    bus4.x3 = 10'h005;
    bus4.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus4.in_valid = 1'b0;
    n = 0;
    while (!bus4.out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("frac4.outValid", 32'(bus4.out_valid), 32'd1);
    checkOutput("frac4.y", 32'(bus4.y), 32'h0C5);
    checkOutput("frac4.ovf", 32'(bus4.ovf), 32'd0);
    @(posedge clk);
    #1;
    exp = model(10'h3FF, 10'h3FF, 10'h000, 4);
    bus4.x1 = 10'h3FF;
    bus4.x2 = 10'h3FF;
    bus4.x3 = 10'h000;
    bus4.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus4.in_valid = 1'b0;
    n = 0;
    while (!bus4.out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("frac4big.outValid", 32'(bus4.out_valid), 32'd1);
    checkOutput("frac4big.y", 32'(bus4.y), 32'(exp[9:0]));
    checkOutput("frac4big.ovf", 32'(bus4.ovf), 32'd1);

    // Backpressure: result must hold while a competing triple is offered and ignored.
    bus.out_ready = 1'b0;
    applyStimulus(10'h010, 10'h004, 10'h001);
    waitValid();
    checkOutput("bp.y", 32'(bus.y), 32'h041);
    for (int i = 0; i < 5; i++) begin
      bus.x1       = 10'h155;
      bus.x2       = 10'h2AA;
      bus.x3       = 10'h0F0;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("bp.yHeld", 32'(bus.y), 32'h041);
      checkOutput("bp.validHeld", 32'(bus.out_valid), 32'd1);
      checkOutput("bp.inReadyLow", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp.inReadyBack", 32'(bus.in_ready), 32'd1);
    checkOutput("bp.validDropped", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("bp.noPhantomJob", 32'(bus.in_ready), 32'd1);

    // Asynchronous reset during the fourth multiply cycle clears everything at once.
    applyStimulus(10'h00A, 10'h00B, 10'h000);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst.outValid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst.y", 32'(bus.y), 32'd0);
    checkOutput("rst.inReady", 32'(bus.in_ready), 32'd1);
    checkOutput("rst.ovf", 32'(bus.ovf), 32'd0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    runVector("afterRst", 10'h002, 10'h003, 10'h001, 10'h007, 1'b0);

    // Streaming: consumer always ready, accepts must land every 13 cycles.
    prevAccept = 0;
    for (int i = 0; i < 50; i++) begin
      a   = (i % 3 == 0) ? 10'($urandom_range(0, 31)) : 10'($urandom_range(0, 1023));
      b   = (i % 3 == 0) ? 10'($urandom_range(0, 31)) : 10'($urandom_range(0, 1023));
      c   = 10'($urandom_range(0, 1023));
      exp = model(a, b, c, 0);
      runVector($sformatf("stream%0d", i), a, b, c, exp[9:0], exp[10]);
      if (i > 0) begin
        checkOutput($sformatf("stream%0d.spacing", i), 32'(acceptCyc - prevAccept), 32'd13);
      end
      prevAccept = acceptCyc;
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end
endmodule
